// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with START/BUSY/DONE handshake, iterative rotates and an
// optional radix-2 shift-add multiplier on opcode A (enabled by defining ALU_SEQ_MUL_EN).
module alu_seq #(
  parameter int DWIDTH = 8,
  parameter int IWIDTH = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              START,
  input  logic [IWIDTH-1:0] in_instr,
  input  logic [DWIDTH-1:0] IN_A,
  input  logic [DWIDTH-1:0] IN_B,
  input  logic              Cin,
  input  logic              Bin,
  output logic              BUSY,
  output logic              DONE,
  output logic [DWIDTH-1:0] OUT,
  output logic [DWIDTH-1:0] OUT_HI,
  output logic              Cout,
  output logic              Bout,
  output logic              Z
);
  localparam int CW = $clog2(DWIDTH);
`ifdef ALU_SEQ_MUL_EN
  localparam int AW = 2*DWIDTH;
`else
  localparam int AW = DWIDTH;
`endif

  localparam logic [IWIDTH-1:0] OP_NOT = 4'h0, OP_XOR = 4'h1, OP_OR  = 4'h2, OP_AND = 4'h3,
                                OP_SUB = 4'h4, OP_ADD = 4'h5, OP_RR  = 4'h6, OP_RL  = 4'h7,
                                OP_DEC = 4'h8, OP_INC = 4'h9, OP_MUL = 4'hA, OP_ROR = 4'hB,
                                OP_ROL = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_load;
  logic [IWIDTH-1:0] op_q, op_d;
  logic [DWIDTH-1:0] a_q, a_d, b_q, b_d;
  logic              cin_q, cin_d, bin_q, bin_d;
  logic [AW-1:0]     acc_q, acc_d, acc_step;
  logic [DWIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
  logic              cout_q, cout_d, bout_q, bout_d, z_q, z_d;

  logic [DWIDTH-1:0] rot_src, rot_step, res_lo, res_hi;
  logic [DWIDTH:0]   sum_ext, dif_ext, inc_ext, dec_ext;
  logic              res_c, res_b;

  // Rotates: acc holds A and advances one bit per RUN cycle.
  always_comb begin
    rot_src = acc_q[DWIDTH-1:0];
    if (b_q[CW-1:0] == '0)
      rot_step = rot_src;
    else if (op_q == OP_ROR)
      rot_step = {rot_src[0], rot_src[DWIDTH-1:1]};
    else
      rot_step = {rot_src[DWIDTH-2:0], rot_src[DWIDTH-1]};
  end

`ifdef ALU_SEQ_MUL_EN
  // acc = {partial high, remaining multiplier bits}; each step adds A then shifts right.
  logic [DWIDTH:0]   mul_sum;
  logic [AW-1:0]     mul_step;
  always_comb begin
    mul_sum  = {1'b0, acc_q[AW-1:DWIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_step = {mul_sum, acc_q[DWIDTH-1:1]};
    acc_step = (op_q == OP_MUL) ? mul_step : AW'(rot_step);
  end
`else
  always_comb acc_step = rot_step;
`endif

  always_comb begin
    sum_ext = {1'b0, a_q} + {1'b0, b_q} + (DWIDTH+1)'(cin_q);
    dif_ext = {1'b0, a_q} - {1'b0, b_q} - (DWIDTH+1)'(bin_q);
    inc_ext = {1'b0, a_q} + (DWIDTH+1)'(1);
    dec_ext = {1'b0, a_q} - (DWIDTH+1)'(1);
    res_lo  = b_q;
    res_hi  = '0;
    res_c   = 1'b0;
    res_b   = 1'b0;
    case (op_q)
      OP_NOT:         res_lo = ~a_q;
      OP_XOR:         res_lo = a_q ^ b_q;
      OP_OR:          res_lo = a_q | b_q;
      OP_AND:         res_lo = a_q & b_q;
      OP_SUB:         {res_b, res_lo} = dif_ext;
      OP_ADD:         {res_c, res_lo} = sum_ext;
      OP_RR:          res_lo = {1'b0, a_q[DWIDTH-1:1]};
      OP_RL:          res_lo = {a_q[DWIDTH-2:0], 1'b0};
      OP_DEC:         {res_b, res_lo} = dec_ext;
      OP_INC:         {res_c, res_lo} = inc_ext;
      OP_ROR, OP_ROL: res_lo = rot_step;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:         {res_hi, res_lo} = mul_step;
`endif
      default:        res_lo = b_q;
    endcase
  end

  // RUN lasts cnt_load+1 cycles, i.e. the op latency L.
  always_comb begin
    cnt_load = '0;
    if ((in_instr == OP_ROR || in_instr == OP_ROL) && IN_B[CW-1:0] != '0)
      cnt_load = IN_B[CW-1:0] - CW'(1);
`ifdef ALU_SEQ_MUL_EN
    if (in_instr == OP_MUL)
      cnt_load = CW'(DWIDTH-1);
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    bin_d    = bin_q;
    acc_d    = acc_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    cout_d   = cout_q;
    bout_d   = bout_q;
    z_d      = z_q;
    case (state_q)
      // FIN's closing edge may accept the next op, giving one op per L+1 cycles.
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (START) begin
          state_d = S_RUN;
          cnt_d   = cnt_load;
          op_d    = in_instr;
          a_d     = IN_A;
          b_d     = IN_B;
          cin_d   = Cin;
          bin_d   = Bin;
          acc_d   = (in_instr == OP_MUL) ? AW'(IN_B) : AW'(IN_A);
        end
      end
      S_RUN: begin
        acc_d = acc_step;
        if (cnt_q == '0) begin
          state_d  = S_FIN;
          out_d    = res_lo;
          out_hi_d = res_hi;
          cout_d   = res_c;
          bout_d   = res_b;
          z_d      = ({res_hi, res_lo} == '0);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      bin_q    <= 1'b0;
      acc_q    <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      cout_q   <= 1'b0;
      bout_q   <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      bin_q    <= bin_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      cout_q   <= cout_d;
      bout_q   <= bout_d;
      z_q      <= z_d;
    end
  end

  assign BUSY   = (state_q == S_RUN) || (state_q == S_FIN);
  assign DONE   = (state_q == S_FIN);
  assign OUT    = out_q;
  assign OUT_HI = out_hi_q;
  assign Cout   = cout_q;
  assign Bout   = bout_q;
  assign Z      = z_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (DWIDTH=8): directed vector table, back-to-back,
// mid-op reset, and random ops against a plain-arithmetic reference model.
module tb_alu_seq;
  logic       CLK, nRST, START, Cin, Bin;
  logic [3:0] in_instr;
  logic [7:0] IN_A, IN_B;
  logic       BUSY, DONE, Cout, Bout, Z;
  logic [7:0] OUT, OUT_HI;

  int checks = 0;
  int failures = 0;

  alu_seq #(.DWIDTH(8), .IWIDTH(4)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .in_instr(in_instr), .IN_A(IN_A), .IN_B(IN_B),
    .Cin(Cin), .Bin(Bin), .BUSY(BUSY), .DONE(DONE), .OUT(OUT), .OUT_HI(OUT_HI),
    .Cout(Cout), .Bout(Bout), .Z(Z)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] out;
    logic [7:0] hi;
    logic       co;
    logic       bo;
    logic       z;
    int         lat;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       bi;
    exp_t       e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: straight integer arithmetic on the opcode definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a8,
                                 input logic [7:0] b8, input logic ci, input logic bi);
    exp_t e;
    int a, b, r, n, p;
    a = int'(a8); b = int'(b8); n = b % 8; r = b; p = 0;
    e = '{out: 8'h00, hi: 8'h00, co: 1'b0, bo: 1'b0, z: 1'b0, lat: 1};
    case (op)
      4'h0: r = 255 - a;
      4'h1: r = a ^ b;
      4'h2: r = a | b;
      4'h3: r = a & b;
      4'h4: begin r = a - b - int'(bi); e.bo = (r < 0); end
      4'h5: begin r = a + b + int'(ci); e.co = (r > 255); end
      4'h6: r = a / 2;
      4'h7: r = a * 2;
      4'h8: begin r = a - 1; e.bo = (r < 0); end
      4'h9: begin r = a + 1; e.co = (r > 255); end
      4'hB: begin r = (n == 0) ? a : ((a >> n) | (a << (8 - n))); e.lat = (n == 0) ? 1 : n; end
      4'hC: begin r = (n == 0) ? a : ((a << n) | (a >> (8 - n))); e.lat = (n == 0) ? 1 : n; end
`ifdef ALU_SEQ_MUL_EN
      4'hA: begin p = a * b; r = p; e.lat = 8; end
`endif
      default: r = b;
    endcase
    e.out = r[7:0];
    e.hi  = p[15:8];
    e.z   = (e.out == 8'h00) && (e.hi == 8'h00);
    return e;
  endfunction

  // Issue one op from idle, scramble inputs after acceptance, and check result and timing.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic bi, input exp_t e, input string nm);
    int cyc;
    logic [7:0] prev;
    logic held;
    @(negedge CLK);
    prev = OUT;
    in_instr = op; IN_A = a; IN_B = b; Cin = ci; Bin = bi; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    in_instr = 4'($urandom); IN_A = 8'($urandom); IN_B = 8'($urandom);
    Cin = 1'($urandom); Bin = 1'($urandom);
    held = 1'b1;
    cyc = 0;
    while (!DONE && cyc < 40) begin
      if (OUT !== prev) held = 1'b0;
      @(negedge CLK);
      cyc++;
    end
    chk({nm, ".lat"}, cyc, e.lat);
    chk({nm, ".hold"}, {31'd0, held}, 32'd1);
    chk({nm, ".out"}, {OUT_HI, OUT}, {e.hi, e.out});
    chk({nm, ".flags"}, {Cout, Bout, Z}, {e.co, e.bo, e.z});
    @(negedge CLK);
    chk({nm, ".pulse"}, {DONE, BUSY}, 2'b00);
    chk({nm, ".keep"}, OUT, e.out);
  endtask

  vec_t vecs[$];
  exp_t ex;

  initial begin
    int cyc;
    logic saw_done;
    logic [3:0] bop[3];
    logic [7:0] ba[3], bb[3], bout_exp[3];
    int blat[3];

    nRST = 1'b0; START = 1'b0; in_instr = '0; IN_A = '0; IN_B = '0; Cin = 1'b0; Bin = 1'b0;

    // op, a, b, cin, bin, {out, hi, co, bo, z, L}
    vecs.push_back('{4'h5, 8'hF0, 8'h20, 1'b1, 1'b0, '{8'h11, 8'h00, 1'b1, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'h4, 8'h05, 8'h05, 1'b0, 1'b0, '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1}});
    vecs.push_back('{4'h4, 8'h00, 8'h01, 1'b0, 1'b0, '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1}});
    vecs.push_back('{4'h9, 8'hFF, 8'h00, 1'b1, 1'b0, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1}});
    vecs.push_back('{4'hB, 8'h81, 8'h03, 1'b0, 1'b0, '{8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 3}});
    vecs.push_back('{4'hC, 8'h81, 8'h01, 1'b0, 1'b0, '{8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'hB, 8'h81, 8'h00, 1'b1, 1'b1, '{8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'hB, 8'h01, 8'hFF, 1'b0, 1'b0, '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 7}});
    vecs.push_back('{4'hC, 8'h01, 8'h07, 1'b0, 1'b0, '{8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 7}});
    vecs.push_back('{4'h0, 8'h0F, 8'h00, 1'b0, 1'b0, '{8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'h1, 8'hA5, 8'hFF, 1'b0, 1'b0, '{8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'h2, 8'h50, 8'h05, 1'b0, 1'b0, '{8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'h3, 8'hF0, 8'h3C, 1'b0, 1'b0, '{8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'h4, 8'h10, 8'h01, 1'b0, 1'b1, '{8'h0E, 8'h00, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'h5, 8'hFF, 8'h00, 1'b1, 1'b0, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1}});
    vecs.push_back('{4'h8, 8'h00, 8'h00, 1'b0, 1'b0, '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1}});
    vecs.push_back('{4'h8, 8'h01, 8'h00, 1'b0, 1'b0, '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1}});
    vecs.push_back('{4'h6, 8'h81, 8'h00, 1'b0, 1'b0, '{8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'h7, 8'h81, 8'h00, 1'b0, 1'b0, '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'hD, 8'h11, 8'hC3, 1'b0, 1'b0, '{8'hC3, 8'h00, 1'b0, 1'b0, 1'b0, 1}});
    vecs.push_back('{4'hF, 8'h11, 8'h00, 1'b0, 1'b0, '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1}});
`ifdef ALU_SEQ_MUL_EN
    vecs.push_back('{4'hA, 8'hFF, 8'hFF, 1'b1, 1'b1, '{8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 8}});
    vecs.push_back('{4'hA, 8'h00, 8'h37, 1'b0, 1'b0, '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8}});
    vecs.push_back('{4'hA, 8'h0D, 8'h0B, 1'b0, 1'b0, '{8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, 8}});
`else
    vecs.push_back('{4'hA, 8'h00, 8'h5A, 1'b1, 1'b0, '{8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1}});
`endif

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_state", {BUSY, DONE, OUT, OUT_HI, Cout, Bout, Z}, 21'd0);
    nRST = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].bi, vecs[i].e,
             $sformatf("vec%0d", i));

    // START held high across three ops; inputs for the next op present during RUN.
    bop[0] = 4'h5; ba[0] = 8'h10; bb[0] = 8'h22; bout_exp[0] = 8'h32; blat[0] = 1;
    bop[1] = 4'hB; ba[1] = 8'h0F; bb[1] = 8'h02; bout_exp[1] = 8'hC3; blat[1] = 2;
    bop[2] = 4'h1; ba[2] = 8'h3C; bb[2] = 8'hFF; bout_exp[2] = 8'hC3; blat[2] = 1;
    @(negedge CLK);
    Cin = 1'b0; Bin = 1'b0;
    in_instr = bop[0]; IN_A = ba[0]; IN_B = bb[0]; START = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (i < 2) begin
        in_instr = bop[i+1]; IN_A = ba[i+1]; IN_B = bb[i+1];
      end else begin
        START = 1'b0;
      end
      cyc = 0;
      while (!DONE && cyc < 40) begin
        @(negedge CLK);
        cyc++;
      end
      chk($sformatf("b2b%0d.lat", i), cyc, blat[i]);
      chk($sformatf("b2b%0d.out", i), OUT, bout_exp[i]);
    end
    @(negedge CLK);
    chk("b2b.idle", {DONE, BUSY}, 2'b00);

    // Reset in the middle of a 7-cycle rotate.
    run_op(4'h0, 8'h00, 8'h00, 1'b0, 1'b0, '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1}, "pre_rst");
    @(negedge CLK);
    in_instr = 4'hB; IN_A = 8'hA5; IN_B = 8'h07; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1 chk("midrst.async", {BUSY, DONE, OUT, OUT_HI, Cout, Bout, Z}, 21'd0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (DONE || BUSY) saw_done = 1'b1;
    end
    chk("midrst.no_done", {31'd0, saw_done}, 32'd0);
    run_op(4'h5, 8'h01, 8'h01, 1'b0, 1'b0, '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1}, "post_rst");

    // Random ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      logic [7:0] a, b;
      logic ci, bi;
      op = 4'($urandom_range(0, 15));
      a = 8'($urandom); b = 8'($urandom);
      ci = 1'($urandom); bi = 1'($urandom);
      ex = model(op, a, b, ci, bi);
      run_op(op, a, b, ci, bi, ex, $sformatf("rnd%0d_op%0h", i, op));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
